// File: rtl/mtod_sync_pkg.sv
// Shared definitions for the PPS-to-master-ToD alignment sequencer:
// FSM state encoding, CSR word addresses and field widths.
package mtod_sync_pkg;

  localparam int TOD_SEC_W       = 48;
  localparam int TOD_NS_W        = 32;
  localparam int CSR_DW          = 32;
  localparam int PPS_AW          = 6;
  localparam int TOD_AW          = 4;
  localparam int TIMEOUT_CYC_DEF = 1024;

  // PPS-load-ToD CSR word addresses
  localparam logic [PPS_AW-1:0] PPS_ADDR_SEC_HI  = 6'h00;
  localparam logic [PPS_AW-1:0] PPS_ADDR_SEC_LO  = 6'h01;
  localparam logic [PPS_AW-1:0] PPS_ADDR_NS      = 6'h02;
  localparam logic [PPS_AW-1:0] PPS_ADDR_IRQ_CLR = 6'h08;

  // Master ToD CSR word addresses; the NS write commits the load
  localparam logic [TOD_AW-1:0] TOD_ADDR_SEC_HI = 4'h0;
  localparam logic [TOD_AW-1:0] TOD_ADDR_SEC_LO = 4'h1;
  localparam logic [TOD_AW-1:0] TOD_ADDR_NS     = 4'h2;

  localparam logic [CSR_DW-1:0] IRQ_CLR_VAL = 32'h1;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_RD_SHI  = 4'd1,
    ST_RD_SLO  = 4'd2,
    ST_RD_NS   = 4'd3,
    ST_CALC    = 4'd4,
    ST_WR_SHI  = 4'd5,
    ST_WR_SLO  = 4'd6,
    ST_WR_NS   = 4'd7,
    ST_CLR_IRQ = 4'd8,
    ST_DONE    = 4'd9,
    ST_ERR     = 4'd10
  } sync_state_e;

  // Seconds value of the next boundary; wraps modulo 2^48
  function automatic logic [TOD_SEC_W-1:0] next_second(input logic [TOD_SEC_W-1:0] sec);
    return sec + TOD_SEC_W'(1);
  endfunction

endpackage

// File: rtl/mtod_avmm_xfer.sv
// Single-transfer Avalon-MM host engine. The requester holds req/we/addr/wdata
// stable for the whole transfer; this block drives the bus, reports completion
// (with read data sampled in the same cycle) and flags a transfer that has
// waited TIMEOUT_CYC cycles on waitrequest.
module mtod_avmm_xfer
  import mtod_sync_pkg::*;
#(
  parameter int AW          = 6,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [CSR_DW-1:0] wdata_i,
  output logic              done_o,
  output logic              timeout_o,
  output logic [CSR_DW-1:0] rdata_o,
  output logic [AW-1:0]     avm_address_o,
  output logic              avm_read_o,
  output logic              avm_write_o,
  output logic [CSR_DW-1:0] avm_writedata_o,
  input  logic [CSR_DW-1:0] avm_readdata_i,
  input  logic              avm_waitrequest_i
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_last;

  // Bus drive follows the request directly; idle bus is all zeros
  always_comb begin
    avm_read_o      = req_i & ~we_i;
    avm_write_o     = req_i & we_i;
    avm_address_o   = req_i ? addr_i : '0;
    avm_writedata_o = (req_i & we_i) ? wdata_i : '0;
    rdata_o         = avm_readdata_i;
    cnt_last        = (cnt_q == CNT_LAST);
    done_o          = req_i & ~avm_waitrequest_i;
    timeout_o       = req_i & avm_waitrequest_i & cnt_last;
  end

  // Wait counter: runs only while stalled, restarts on completion, timeout or idle
  always_comb begin
    cnt_d = '0;
    if (req_i && avm_waitrequest_i && !cnt_last) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Wait counter register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mtod_pps_sync_ctrl.sv
// Re-aligns the master ToD counter to the external 1PPS reference: on each PPS
// capture IRQ it reads the captured ToD, computes the next second boundary,
// loads it into the master ToD and clears the IRQ.
// Optional statistics outputs are built when MTOD_SYNC_STATS_EN is defined.
module mtod_pps_sync_ctrl
  import mtod_sync_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_enable,
  input  logic [TOD_NS_W-1:0] i_ns_offset,
  input  logic                i_pps_irq,
  output logic [PPS_AW-1:0]   o_pps_address,
  output logic                o_pps_read,
  output logic                o_pps_write,
  output logic [CSR_DW-1:0]   o_pps_writedata,
  input  logic [CSR_DW-1:0]   i_pps_readdata,
  input  logic                i_pps_waitrequest,
  output logic [TOD_AW-1:0]   o_tod_address,
  output logic                o_tod_write,
  output logic [CSR_DW-1:0]   o_tod_writedata,
  input  logic                i_tod_waitrequest,
  output logic                o_busy,
  output logic                o_sync_done,
  output logic                o_err
`ifdef MTOD_SYNC_STATS_EN
  ,
  output logic [15:0]         o_sync_cnt,
  output logic [15:0]         o_err_cnt,
  output logic [31:0]         o_last_ns_err
`endif
);

  sync_state_e state_q, state_d;

  logic [15:0]          cap_sec_hi_q, cap_sec_hi_d;
  logic [31:0]          cap_sec_lo_q, cap_sec_lo_d;
  logic [TOD_NS_W-1:0]  cap_ns_q, cap_ns_d;
  logic [TOD_SEC_W-1:0] sec_next_q, sec_next_d;
  logic [TOD_NS_W-1:0]  ns_next_q, ns_next_d;
  logic                 armed_q, armed_d;
  logic                 err_q, err_d;
  logic                 enable_q;

  logic                pps_req, pps_we, pps_done, pps_timeout;
  logic [PPS_AW-1:0]   pps_addr;
  logic [CSR_DW-1:0]   pps_wdata, pps_rdata;
  logic                tod_req, tod_done, tod_timeout;
  logic [TOD_AW-1:0]   tod_addr;
  logic [CSR_DW-1:0]   tod_wdata;
  logic                tod_read_unused;
  logic [CSR_DW-1:0]   tod_rdata_unused;
  logic                trigger, any_timeout;

  mtod_avmm_xfer #(.AW(PPS_AW), .TIMEOUT_CYC(TIMEOUT_CYC)) u_pps_xfer (
    .clk_i             (i_clk),
    .rst_ni            (i_rst_n),
    .req_i             (pps_req),
    .we_i              (pps_we),
    .addr_i            (pps_addr),
    .wdata_i           (pps_wdata),
    .done_o            (pps_done),
    .timeout_o         (pps_timeout),
    .rdata_o           (pps_rdata),
    .avm_address_o     (o_pps_address),
    .avm_read_o        (o_pps_read),
    .avm_write_o       (o_pps_write),
    .avm_writedata_o   (o_pps_writedata),
    .avm_readdata_i    (i_pps_readdata),
    .avm_waitrequest_i (i_pps_waitrequest)
  );

  mtod_avmm_xfer #(.AW(TOD_AW), .TIMEOUT_CYC(TIMEOUT_CYC)) u_tod_xfer (
    .clk_i             (i_clk),
    .rst_ni            (i_rst_n),
    .req_i             (tod_req),
    .we_i              (1'b1),
    .addr_i            (tod_addr),
    .wdata_i           (tod_wdata),
    .done_o            (tod_done),
    .timeout_o         (tod_timeout),
    .rdata_o           (tod_rdata_unused),
    .avm_address_o     (o_tod_address),
    .avm_read_o        (tod_read_unused),
    .avm_write_o       (o_tod_write),
    .avm_writedata_o   (o_tod_writedata),
    .avm_readdata_i    ('0),
    .avm_waitrequest_i (i_tod_waitrequest)
  );

  // Transfer request decode: each bus state owns exactly one transfer
  always_comb begin
    pps_req   = 1'b0;
    pps_we    = 1'b0;
    pps_addr  = '0;
    pps_wdata = '0;
    tod_req   = 1'b0;
    tod_addr  = '0;
    tod_wdata = '0;
    case (state_q)
      ST_RD_SHI:  begin pps_req = 1'b1; pps_addr = PPS_ADDR_SEC_HI; end
      ST_RD_SLO:  begin pps_req = 1'b1; pps_addr = PPS_ADDR_SEC_LO; end
      ST_RD_NS:   begin pps_req = 1'b1; pps_addr = PPS_ADDR_NS; end
      ST_WR_SHI:  begin
        tod_req   = 1'b1;
        tod_addr  = TOD_ADDR_SEC_HI;
        tod_wdata = CSR_DW'(sec_next_q[TOD_SEC_W-1:32]);
      end
      ST_WR_SLO:  begin
        tod_req   = 1'b1;
        tod_addr  = TOD_ADDR_SEC_LO;
        tod_wdata = sec_next_q[31:0];
      end
      ST_WR_NS:   begin
        tod_req   = 1'b1;
        tod_addr  = TOD_ADDR_NS;
        tod_wdata = ns_next_q;
      end
      ST_CLR_IRQ: begin
        pps_req   = 1'b1;
        pps_we    = 1'b1;
        pps_addr  = PPS_ADDR_IRQ_CLR;
        pps_wdata = IRQ_CLR_VAL;
      end
      default: ;
    endcase
  end

  // Sequencer next state: advance on completion, divert to ERR on any timeout
  always_comb begin
    trigger     = (state_q == ST_IDLE) && i_enable && i_pps_irq && armed_q;
    any_timeout = pps_timeout | tod_timeout;
    state_d     = state_q;
    case (state_q)
      ST_IDLE:    if (trigger) state_d = ST_RD_SHI;
      ST_RD_SHI:  if (pps_timeout) state_d = ST_ERR; else if (pps_done) state_d = ST_RD_SLO;
      ST_RD_SLO:  if (pps_timeout) state_d = ST_ERR; else if (pps_done) state_d = ST_RD_NS;
      ST_RD_NS:   if (pps_timeout) state_d = ST_ERR; else if (pps_done) state_d = ST_CALC;
      ST_CALC:    state_d = ST_WR_SHI;
      ST_WR_SHI:  if (tod_timeout) state_d = ST_ERR; else if (tod_done) state_d = ST_WR_SLO;
      ST_WR_SLO:  if (tod_timeout) state_d = ST_ERR; else if (tod_done) state_d = ST_WR_NS;
      ST_WR_NS:   if (tod_timeout) state_d = ST_ERR; else if (tod_done) state_d = ST_CLR_IRQ;
      ST_CLR_IRQ: if (pps_timeout) state_d = ST_ERR; else if (pps_done) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      ST_ERR:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Capture, next-boundary calculation, re-arm and sticky error flag
  always_comb begin
    cap_sec_hi_d = cap_sec_hi_q;
    cap_sec_lo_d = cap_sec_lo_q;
    cap_ns_d     = cap_ns_q;
    sec_next_d   = sec_next_q;
    ns_next_d    = ns_next_q;
    armed_d      = armed_q;
    err_d        = err_q;
    if (pps_done && (state_q == ST_RD_SHI)) cap_sec_hi_d = pps_rdata[15:0];
    if (pps_done && (state_q == ST_RD_SLO)) cap_sec_lo_d = pps_rdata;
    if (pps_done && (state_q == ST_RD_NS))  cap_ns_d     = pps_rdata;
    if (state_q == ST_CALC) begin
      sec_next_d = next_second({cap_sec_hi_q, cap_sec_lo_q});
      ns_next_d  = i_ns_offset;
    end
    // A stale IRQ level must be seen low before another sequence may start
    if (!i_pps_irq) armed_d = 1'b1;
    if (trigger || (state_q == ST_CLR_IRQ) || (state_q == ST_ERR)) armed_d = 1'b0;
    if (i_enable && !enable_q) err_d = 1'b0;
    if (any_timeout) err_d = 1'b1;
  end

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      cap_sec_hi_q <= '0;
      cap_sec_lo_q <= '0;
      cap_ns_q     <= '0;
      sec_next_q   <= '0;
      ns_next_q    <= '0;
      armed_q      <= 1'b0;
      err_q        <= 1'b0;
      enable_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_sec_hi_q <= cap_sec_hi_d;
      cap_sec_lo_q <= cap_sec_lo_d;
      cap_ns_q     <= cap_ns_d;
      sec_next_q   <= sec_next_d;
      ns_next_q    <= ns_next_d;
      armed_q      <= armed_d;
      err_q        <= err_d;
      enable_q     <= i_enable;
    end
  end

  assign o_busy      = (state_q != ST_IDLE);
  assign o_sync_done = (state_q == ST_DONE);
  assign o_err       = err_q;

`ifdef MTOD_SYNC_STATS_EN
  logic [15:0] sync_cnt_q, err_cnt_q;

  // Saturating counters of completed loads and timeouts
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if ((state_q == ST_DONE) && (sync_cnt_q != 16'hFFFF)) sync_cnt_q <= sync_cnt_q + 16'd1;
      if (any_timeout && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign o_sync_cnt    = sync_cnt_q;
  assign o_err_cnt     = err_cnt_q;
  assign o_last_ns_err = cap_ns_q;
`else
  logic cap_ns_unused;
  assign cap_ns_unused = ^cap_ns_q;
`endif

endmodule
